// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_pkg
// Shared definitions for the pushbutton conditioner:
//   - deb_state_e           : per-channel debounce FSM state encoding
//   - DEFAULT_STABLE_CYCLES : stability window for the 50 MHz board clock (20 ms)
// -----------------------------------------------------------------------------
package button_debouncer_pkg;

  localparam int DEFAULT_STABLE_CYCLES = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_DEB_DOWN = 2'b01,
    ST_HELD     = 2'b10,
    ST_DEB_UP   = 2'b11
  } deb_state_e;

endpackage : button_debouncer_pkg

// File: rtl/button_debouncer_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// Single pushbutton channel: 2-flop synchroniser, 4-state debounce FSM with a
// stability counter, and registered level / press / release outputs.
// Ports:
//   clk_i       : system clock, rising edge
//   rst_ni      : asynchronous active-low reset
//   btn_raw_i   : raw asynchronous bouncy button, active-high
//   level_o     : debounced level
//   press_o     : one-cycle pulse when level_o rises
//   release_o   : one-cycle pulse when level_o falls
// -----------------------------------------------------------------------------
module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CW            = $clog2(STABLE_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  deb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Two-flop synchroniser bringing the raw button into the clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce FSM: next state, counter and output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        level_d = 1'b0;
        if (sync2_q) begin
          state_d = ST_DEB_DOWN;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEB_DOWN: begin
        if (!sync2_q) begin
          // Bounce: fall back silently, level was never changed.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        level_d = 1'b1;
        if (!sync2_q) begin
          state_d = ST_DEB_UP;
          cnt_d   = '0;
        end else begin
          state_d = ST_HELD;
        end
      end
      ST_DEB_UP: begin
        if (sync2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule : debounce_channel

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// N independent pushbutton conditioners (one debounce_channel per bit).
// Ports:
//   clock       : system clock, rising edge
//   reset       : asynchronous active-low reset
//   btn_raw     : N raw asynchronous bouncy buttons, active-high
//   btn_level   : N debounced levels
//   btn_press   : N one-cycle pulses on accepted rising level
//   btn_release : N one-cycle pulses on accepted falling level
// -----------------------------------------------------------------------------
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int N             = 4,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CW            = $clog2(STABLE_CYCLES)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CW           (CW)
    ) u_ch (
      .clk_i    (clock),
      .rst_ni   (reset),
      .btn_raw_i(btn_raw[g]),
      .level_o  (btn_level[g]),
      .press_o  (btn_press[g]),
      .release_o(btn_release[g])
    );
  end

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  localparam int N  = 2;
  localparam int SC = 4;

  logic         clock;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int checks = 0;
  int errors = 0;

  // Per-channel observations accumulated over a window of cycles.
  int           pcnt [N];
  int           rcnt [N];
  int           both_cnt;
  logic [N-1:0] lvl_or;
  logic [N-1:0] lvl_and;

  button_debouncer #(
    .N            (N),
    .STABLE_CYCLES(SC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      pcnt[i] = 0;
      rcnt[i] = 0;
    end
    both_cnt = 0;
    lvl_or   = '0;
    lvl_and  = '1;
  endtask

  // Advance n clocks, sampling outputs on the falling edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      for (int i = 0; i < N; i++) begin
        pcnt[i] += int'(btn_press[i]);
        rcnt[i] += int'(btn_release[i]);
        if (btn_press[i] && btn_release[i]) both_cnt++;
      end
      lvl_or  = lvl_or | btn_level;
      lvl_and = lvl_and & btn_level;
    end
  endtask

  logic [6:0] bounce;

  initial begin
    reset   = 1'b0;
    btn_raw = 2'b11;
    clr();

    // Reset held with buttons pressed.
    cyc(4);
    chk("rst_level", 32'(btn_level), 32'h0);
    chk("rst_press_cnt", 32'(pcnt[0] + pcnt[1]), 32'h0);
    chk("rst_release", 32'(btn_release), 32'h0);

    // Release reset: held buttons become a new press at edge 6.
    reset = 1'b1;
    clr();
    cyc(6);
    chk("rel_no_early_press", 32'(pcnt[0] + pcnt[1]), 32'h0);
    chk("rel_no_early_level", 32'(lvl_or), 32'h0);
    cyc(1);
    chk("rel_press", 32'(btn_press), 32'h3);
    chk("rel_level", 32'(btn_level), 32'h3);
    cyc(1);
    chk("rel_press_1cyc", 32'(btn_press), 32'h0);

    // Let both go.
    btn_raw = 2'b00;
    clr();
    cyc(6);
    chk("both_rel_early", 32'(rcnt[0] + rcnt[1]), 32'h0);
    cyc(1);
    chk("both_release", 32'(btn_release), 32'h3);
    chk("both_rel_level", 32'(btn_level), 32'h0);
    cyc(2);

    // Clean press and release on ch0.
    btn_raw = 2'b01;
    clr();
    cyc(6);
    chk("c0_press_early", 32'(pcnt[0]), 32'h0);
    cyc(1);
    chk("c0_press", 32'(btn_press), 32'h1);
    chk("c0_level", 32'(btn_level), 32'h1);
    clr();
    cyc(5);
    chk("c0_press_once", 32'(pcnt[0]), 32'h0);
    chk("c0_level_held", 32'(lvl_and[0]), 32'h1);
    btn_raw = 2'b00;
    clr();
    cyc(6);
    chk("c0_rel_early", 32'(rcnt[0]), 32'h0);
    cyc(1);
    chk("c0_release", 32'(btn_release), 32'h1);
    chk("c0_rel_level", 32'(btn_level), 32'h0);
    cyc(2);

    // Bounce rejection, press side: 1,1,1,0,1,1,0.
    bounce = 7'b0110111;
    clr();
    for (int i = 0; i < 7; i++) begin
      btn_raw[0] = bounce[i];
      cyc(1);
    end
    btn_raw[0] = 1'b0;
    cyc(8);
    chk("bnc_dn_press", 32'(pcnt[0]), 32'h0);
    chk("bnc_dn_level", 32'(lvl_or[0]), 32'h0);

    // Bounce rejection, release side (mirrored pattern while held).
    btn_raw[0] = 1'b1;
    cyc(8);
    chk("bnc_up_held", 32'(btn_level), 32'h1);
    clr();
    for (int i = 0; i < 7; i++) begin
      btn_raw[0] = ~bounce[i];
      cyc(1);
    end
    btn_raw[0] = 1'b1;
    cyc(8);
    chk("bnc_up_release", 32'(rcnt[0]), 32'h0);
    chk("bnc_up_level", 32'(lvl_and[0]), 32'h1);
    btn_raw[0] = 1'b0;
    cyc(9);

    // Simultaneous press, then release of ch1 only.
    btn_raw = 2'b11;
    clr();
    cyc(7);
    chk("sim_press", 32'(btn_press), 32'h3);
    cyc(3);
    btn_raw = 2'b01;
    clr();
    cyc(7);
    chk("sim_rel1", 32'(btn_release), 32'h2);
    chk("sim_level", 32'(btn_level), 32'h1);
    chk("sim_ch0_quiet", 32'(rcnt[0] + pcnt[0] + pcnt[1]), 32'h0);
    btn_raw = 2'b00;
    cyc(9);

    // Reset in DEB_DOWN (cnt=2 after edge 4).
    btn_raw = 2'b01;
    cyc(5);
    reset = 1'b0;
    #1;
    chk("rst_dd_outputs", {btn_level, btn_press, btn_release}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    clr();
    cyc(6);
    chk("rst_dd_restart", 32'(pcnt[0]), 32'h0);
    cyc(1);
    chk("rst_dd_press", 32'(btn_press), 32'h1);

    // Reset while HELD: asynchronous level drop, no release pulse.
    cyc(3);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_held_level", 32'(btn_level), 32'h0);
    btn_raw = 2'b00;
    clr();
    cyc(3);
    reset = 1'b1;
    cyc(8);
    chk("rst_held_norel", 32'(rcnt[0]), 32'h0);
    chk("rst_held_nolvl", 32'(lvl_or), 32'h0);

    // Minimum stable pulse: 5 samples accepted.
    btn_raw[0] = 1'b1;
    clr();
    cyc(5);
    btn_raw[0] = 1'b0;
    cyc(12);
    chk("min5_press", 32'(pcnt[0]), 32'h1);
    chk("min5_release", 32'(rcnt[0]), 32'h1);
    chk("no_both", 32'(both_cnt), 32'h0);

    // Four samples rejected.
    btn_raw[0] = 1'b1;
    clr();
    cyc(4);
    btn_raw[0] = 1'b0;
    cyc(12);
    chk("min4_press", 32'(pcnt[0]), 32'h0);
    chk("min4_level", 32'(lvl_or), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_button_debouncer
